// File: rtl/branch_predict_unit_pkg.sv
// Shared definitions for the branch predict unit: opcode and REGIMM codes,
// 2-bit counter encodings, branch kind decode and counter transition.
package branch_predict_unit_pkg;

  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;

  localparam logic [4:0] RT_BLTZ   = 5'd0;
  localparam logic [4:0] RT_BGEZ   = 5'd1;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  typedef enum logic [2:0] {
    BR_NONE,
    BR_BEQ,
    BR_BNE,
    BR_BLEZ,
    BR_BGTZ,
    BR_BLTZ,
    BR_BGEZ
  } br_kind_e;

  // Classify an instruction word as one of the resolvable conditional branches.
  function automatic br_kind_e decode_branch(input logic [31:0] instr);
    br_kind_e k;
    k = BR_NONE;
    case (instr[31:26])
      OP_BEQ:  k = BR_BEQ;
      OP_BNE:  k = BR_BNE;
      OP_BLEZ: k = BR_BLEZ;
      OP_BGTZ: k = BR_BGTZ;
      OP_REGIMM: begin
        if (instr[20:16] == RT_BLTZ)      k = BR_BLTZ;
        else if (instr[20:16] == RT_BGEZ) k = BR_BGEZ;
        else                              k = BR_NONE;
      end
      default: k = BR_NONE;
    endcase
    return k;
  endfunction

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    ctr_e n;
    n = c;
    case (c)
      CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  n = taken ? CTR_ST  : CTR_WT;
      default: n = c;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/branch_predict_unit_btb_ram.sv
// Direct-mapped BTB storage: flop array, async reads, one sync write port,
// sync reset clears valid bits and reloads counters.
module btb_ram
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned TAG_W    = 24,
  parameter logic [1:0]  INIT_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  // fetch-side prediction read
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_target,
  output logic [1:0]       rd_ctr,
  // resolve-side lookup of the entry about to be updated
  input  logic [IDX_W-1:0] lk_idx,
  output logic             lk_valid,
  output logic [TAG_W-1:0] lk_tag,
  output logic [1:0]       lk_ctr,
  // write port
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  input  logic [1:0]       wr_ctr
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic             valid_q  [DEPTH];
  logic [1:0]       ctr_q    [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];

  // Valid and counter state: cleared on reset, written through the single port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= INIT_CTR;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_valid;
      ctr_q[wr_idx]   <= wr_ctr;
    end
  end

  // Tag and target payload: meaningless while invalid, so no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];

  assign lk_valid  = valid_q[lk_idx];
  assign lk_tag    = tag_q[lk_idx];
  assign lk_ctr    = ctr_q[lk_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// IF-stage BTB prediction, ID-stage branch resolution with mispredict
// redirect, and saturating branch/mispredict statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned CNT_W    = 32,
  parameter logic [1:0]  INIT_CTR = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             if_pred_taken,
  output logic [31:0]      if_pred_pc,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_rs,
  input  logic [31:0]      id_rt,
  input  logic             id_pred_taken,
  input  logic [31:0]      id_pred_pc,
  output logic             redirect_en,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  logic [IDX_W-1:0] if_idx, id_idx;
  logic [TAG_W-1:0] if_tag, id_tag;
  logic             rd_valid, lk_valid;
  logic [TAG_W-1:0] rd_tag, lk_tag;
  logic [31:0]      rd_target;
  logic [1:0]       rd_ctr, lk_ctr;
  logic             if_hit, id_hit;

  logic             wr_en, wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [31:0]      wr_target;
  logic [1:0]       wr_ctr;

  br_kind_e         kind;
  logic             is_branch, taken, act;
  logic [31:0]      npc, tgt, br_off, actual_pc;

  // Prediction uses only the stored direction, so these bits never matter.
  logic unused_bits;
  assign unused_bits = ^{id_pred_taken, id_instr[25:21], if_pc[1:0], id_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign id_idx = id_pc[IDX_W+1:2];
  assign id_tag = id_pc[31:IDX_W+2];

  btb_ram #(
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W),
    .INIT_CTR (INIT_CTR)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (if_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_ctr    (rd_ctr),
    .lk_idx    (id_idx),
    .lk_valid  (lk_valid),
    .lk_tag    (lk_tag),
    .lk_ctr    (lk_ctr),
    .wr_en     (wr_en),
    .wr_idx    (id_idx),
    .wr_valid  (wr_valid),
    .wr_tag    (wr_tag),
    .wr_target (wr_target),
    .wr_ctr    (wr_ctr)
  );

  // Fetch prediction from the pre-update entry (no write-to-read bypass).
  always_comb begin
    if_hit        = rd_valid && (rd_tag == if_tag);
    if_pred_taken = if_hit && rd_ctr[1];
    if_pred_pc    = if_pred_taken ? rd_target : (if_pc + 32'd4);
  end

  // Branch condition evaluation and corrected next PC.
  always_comb begin
    kind      = decode_branch(id_instr);
    is_branch = (kind != BR_NONE);
    npc       = id_pc + 32'd4;
    br_off    = {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    tgt       = npc + br_off;
    taken     = 1'b0;
    case (kind)
      BR_BEQ:  taken = (id_rs == id_rt);
      BR_BNE:  taken = (id_rs != id_rt);
      BR_BLEZ: taken = ($signed(id_rs) <= 32'sd0);
      BR_BGTZ: taken = ($signed(id_rs) >  32'sd0);
      BR_BLTZ: taken = ($signed(id_rs) <  32'sd0);
      BR_BGEZ: taken = ($signed(id_rs) >= 32'sd0);
      default: taken = 1'b0;
    endcase
    actual_pc   = taken ? tgt : npc;
    act         = id_valid && !id_stall;
    redirect_en = act && !rst && (id_pred_pc != actual_pc);
    redirect_pc = actual_pc;
  end

  // Table write: train hits, allocate misses, drop non-branch aliases.
  always_comb begin
    id_hit    = lk_valid && (lk_tag == id_tag);
    wr_en     = 1'b0;
    wr_valid  = lk_valid;
    wr_tag    = id_tag;
    wr_target = tgt;
    wr_ctr    = lk_ctr;
    if (act && !rst) begin
      if (is_branch) begin
        wr_en    = 1'b1;
        wr_valid = 1'b1;
        if (id_hit) wr_ctr = ctr_next(ctr_e'(lk_ctr), taken);
        else        wr_ctr = taken ? CTR_WT : INIT_CTR;
      end else if (id_hit) begin
        wr_en    = 1'b1;
        wr_valid = 1'b0;
        wr_ctr   = lk_ctr;
      end
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (act && is_branch && (branch_cnt != '1))
        branch_cnt <= branch_cnt + 1'b1;
      if (redirect_en && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed vector table plus
// randomized traffic against an array-based reference model.
module tb_branch_predict_unit;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam int unsigned CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   if_pc;
  logic          if_pred_taken;
  logic [31:0]   if_pred_pc;
  logic          id_valid, id_stall;
  logic [31:0]   id_pc, id_instr, id_rs, id_rt;
  logic          id_pred_taken;
  logic [31:0]   id_pred_pc;
  logic          redirect_en;
  logic [31:0]   redirect_pc;
  logic [CW-1:0] branch_cnt, mispredict_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .IDX_W    (IDX_W),
    .CNT_W    (CW),
    .INIT_CTR (2'b01)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_pc     (if_pred_pc),
    .id_valid       (id_valid),
    .id_stall       (id_stall),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_pred_taken  (id_pred_taken),
    .id_pred_pc     (id_pred_pc),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  localparam logic [31:0] BEQ4  = 32'h10220004;
  localparam logic [31:0] BLEZ4 = 32'h18200004;
  localparam logic [31:0] BGTZ4 = 32'h1C200004;
  localparam logic [31:0] BLTZ4 = 32'h04200004;
  localparam logic [31:0] BGEZ4 = 32'h04210004;
  localparam logic [31:0] ADD   = 32'h00221820;

  typedef struct {
    logic        r;
    logic [31:0] ifpc;
    logic        v;
    logic        s;
    logic [31:0] idpc;
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] pred;
    logic        e_pt;
    logic [31:0] e_ppc;
    logic        e_re;
    logic [31:0] e_rpc;
    int          e_bc;
    int          e_mc;
  } vec_t;

  vec_t tbl[19];

  // reference model state
  bit          m_valid [DEPTH];
  int unsigned m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  int          m_bc, m_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] ifpc, input logic v, input logic s,
                       input logic [31:0] idpc, input logic [31:0] instr,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] pred);
    rst = r; if_pc = ifpc; id_valid = v; id_stall = s; id_pc = idpc;
    id_instr = instr; id_rs = rs; id_rt = rt; id_pred_pc = pred;
    id_pred_taken = (pred != idpc + 32'd4);
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == (pc >> (IDX_W + 2)));
  endfunction

  function automatic logic [31:0] m_predict(input logic [31:0] pc);
    if (m_hit(pc) && m_ctr[m_idx(pc)] >= 2) return m_tgt[m_idx(pc)];
    return pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_ctr[i] = 1; m_tag[i] = 0; m_tgt[i] = '0;
    end
    m_bc = 0; m_mc = 0;
  endtask

  // kind: 0 beq 1 bne 2 blez 3 bgtz 4 bltz 5 bgez 6.. non-branch
  function automatic logic [31:0] mk_instr(input int kind, input logic [15:0] imm);
    logic [31:0] w;
    case (kind)
      0: w = {6'h04, 5'd1, 5'd2, imm};
      1: w = {6'h05, 5'd1, 5'd2, imm};
      2: w = {6'h06, 5'd1, 5'd0, imm};
      3: w = {6'h07, 5'd1, 5'd0, imm};
      4: w = {6'h01, 5'd1, 5'd0, imm};
      5: w = {6'h01, 5'd1, 5'd1, imm};
      6: w = ADD;
      7: w = {6'h23, 5'd1, 5'd2, imm};
      8: w = {6'h01, 5'd1, 5'd2, imm};
      default: w = {6'h02, 10'd0, imm};
    endcase
    return w;
  endfunction

  function automatic bit m_taken(input int kind, input logic [31:0] rs, input logic [31:0] rt);
    case (kind)
      0: return rs == rt;
      1: return rs != rt;
      2: return $signed(rs) <= 0;
      3: return $signed(rs) > 0;
      4: return $signed(rs) < 0;
      5: return $signed(rs) >= 0;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // idle row: nop at pc 0, predicted 4
    //            r   ifpc          v  s  idpc          instr  rs            rt     pred          pt ppc           re rpc        bc mc
    tbl[0]  = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0, 32'h0, 32'h4,   1'b0, 32'h104, 1'b0, 32'h4,   0, 0};
    tbl[1]  = '{1'b0, 32'h100, 1'b1, 1'b0, 32'h100, BEQ4,  32'h5, 32'h5, 32'h104, 1'b0, 32'h104, 1'b1, 32'h114, 0, 0};
    tbl[2]  = '{1'b0, 32'h100, 1'b1, 1'b0, 32'h100, BEQ4,  32'h5, 32'h5, 32'h114, 1'b1, 32'h114, 1'b0, 32'h114, 1, 1};
    tbl[3]  = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0, 32'h0, 32'h4,   1'b1, 32'h114, 1'b0, 32'h4,   2, 1};
    tbl[4]  = '{1'b0, 32'h100, 1'b1, 1'b0, 32'h100, BEQ4,  32'h5, 32'h6, 32'h114, 1'b1, 32'h114, 1'b1, 32'h104, 2, 1};
    tbl[5]  = '{1'b0, 32'h100, 1'b1, 1'b0, 32'h100, BEQ4,  32'h5, 32'h6, 32'h104, 1'b1, 32'h114, 1'b0, 32'h104, 3, 2};
    tbl[6]  = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0, 32'h0, 32'h4,   1'b0, 32'h104, 1'b0, 32'h4,   4, 2};
    tbl[7]  = '{1'b0, 32'h104, 1'b1, 1'b0, 32'h104, BLTZ4, 32'hFFFFFFFF, 32'h0, 32'h108, 1'b0, 32'h108, 1'b1, 32'h118, 4, 2};
    tbl[8]  = '{1'b0, 32'h104, 1'b1, 1'b0, 32'h108, BGEZ4, 32'h0, 32'h0, 32'h10C, 1'b1, 32'h118, 1'b1, 32'h11C, 5, 3};
    tbl[9]  = '{1'b0, 32'h108, 1'b1, 1'b0, 32'h10C, BLEZ4, 32'h1, 32'h0, 32'h110, 1'b1, 32'h11C, 1'b0, 32'h110, 6, 4};
    tbl[10] = '{1'b0, 32'h10C, 1'b1, 1'b0, 32'h110, BGTZ4, 32'h80000000, 32'h0, 32'h114, 1'b0, 32'h110, 1'b0, 32'h114, 7, 4};
    tbl[11] = '{1'b0, 32'h104, 1'b1, 1'b0, 32'h204, ADD,   32'h0, 32'h0, 32'h208, 1'b1, 32'h118, 1'b0, 32'h208, 8, 4};
    tbl[12] = '{1'b0, 32'h104, 1'b1, 1'b0, 32'h104, ADD,   32'h0, 32'h0, 32'h118, 1'b1, 32'h118, 1'b1, 32'h108, 8, 4};
    tbl[13] = '{1'b0, 32'h104, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0, 32'h0, 32'h4,   1'b0, 32'h108, 1'b0, 32'h4,   8, 5};
    tbl[14] = '{1'b0, 32'h108, 1'b1, 1'b1, 32'h108, BEQ4,  32'h1, 32'h2, 32'h11C, 1'b1, 32'h11C, 1'b0, 32'h10C, 8, 5};
    tbl[15] = '{1'b0, 32'h108, 1'b0, 1'b0, 32'h108, BEQ4,  32'h1, 32'h2, 32'h11C, 1'b1, 32'h11C, 1'b0, 32'h10C, 8, 5};
    tbl[16] = '{1'b1, 32'h108, 1'b1, 1'b0, 32'h108, BEQ4,  32'h1, 32'h2, 32'h11C, 1'b1, 32'h11C, 1'b0, 32'h10C, 8, 5};
    tbl[17] = '{1'b0, 32'h108, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0, 32'h0, 32'h4,   1'b0, 32'h10C, 1'b0, 32'h4,   0, 0};
    tbl[18] = '{1'b0, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0, 32'h0, 32'h0, 32'h4,   1'b0, 32'h104, 1'b0, 32'h4,   0, 0};

    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4);
    repeat (2) @(posedge clk);
    #1;

    // directed sequence
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r, tbl[i].ifpc, tbl[i].v, tbl[i].s, tbl[i].idpc, tbl[i].instr,
            tbl[i].rs, tbl[i].rt, tbl[i].pred);
      @(negedge clk);
      chk($sformatf("row%0d.if_pred_taken", i), {31'd0, if_pred_taken}, {31'd0, tbl[i].e_pt});
      chk($sformatf("row%0d.if_pred_pc", i), if_pred_pc, tbl[i].e_ppc);
      chk($sformatf("row%0d.redirect_en", i), {31'd0, redirect_en}, {31'd0, tbl[i].e_re});
      chk($sformatf("row%0d.redirect_pc", i), redirect_pc, tbl[i].e_rpc);
      chk($sformatf("row%0d.branch_cnt", i), 32'(branch_cnt), 32'(tbl[i].e_bc));
      chk($sformatf("row%0d.mispredict_cnt", i), 32'(mispredict_cnt), 32'(tbl[i].e_mc));
      @(posedge clk);
      #1;
    end

    // randomized traffic against the reference model
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4);
    @(posedge clk);
    #1;
    m_reset();
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ipc, dpc, instr, rs, rt, pred, npc, tgt, apc, e_ppc;
      logic [15:0] imm;
      logic        r, v, s, tk, act, br, e_re, hit;
      int          kind, ix;
      r    = ($urandom_range(0, 99) == 0);
      v    = ($urandom_range(0, 99) < 85);
      s    = ($urandom_range(0, 99) < 20);
      dpc  = {20'd0, 10'($urandom_range(0, 511)), 2'b00};
      ipc  = ($urandom_range(0, 3) == 0) ? dpc : {20'd0, 10'($urandom_range(0, 511)), 2'b00};
      kind = $urandom_range(0, 9);
      imm  = 16'($signed($urandom_range(0, 63)) - 32);
      instr = mk_instr(kind, imm);
      rs   = pick_val();
      rt   = ($urandom_range(0, 2) == 0) ? rs : pick_val();
      br   = (kind <= 5);
      npc  = dpc + 32'd4;
      tgt  = npc + 32'($signed(imm)) * 4;
      tk   = br && m_taken(kind, rs, rt);
      apc  = tk ? tgt : npc;
      case ($urandom_range(0, 3))
        0: pred = m_predict(dpc);
        1: pred = npc;
        2: pred = tgt;
        default: pred = $urandom;
      endcase
      drive(r, ipc, v, s, dpc, instr, rs, rt, pred);
      act   = v && !s;
      e_re  = act && !r && (pred != apc);
      e_ppc = m_predict(ipc);
      @(negedge clk);
      chk("rand.if_pred_taken", {31'd0, if_pred_taken}, {31'd0, e_ppc != ipc + 32'd4});
      chk("rand.if_pred_pc", if_pred_pc, e_ppc);
      chk("rand.redirect_en", {31'd0, redirect_en}, {31'd0, e_re});
      chk("rand.redirect_pc", redirect_pc, apc);
      chk("rand.branch_cnt", 32'(branch_cnt), 32'(m_bc));
      chk("rand.mispredict_cnt", 32'(mispredict_cnt), 32'(m_mc));
      // model the clock edge
      ix  = m_idx(dpc);
      hit = m_hit(dpc);
      if (r) begin
        m_reset();
      end else if (act) begin
        if (br) begin
          if (hit) m_ctr[ix] = tk ? ((m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3)
                                  : ((m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0);
          else     m_ctr[ix] = tk ? 2 : 1;
          m_valid[ix] = 1;
          m_tag[ix]   = dpc >> (IDX_W + 2);
          m_tgt[ix]   = tgt;
          m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
        end else if (hit) begin
          m_valid[ix] = 0;
        end
        if (e_re) m_mc = (m_mc < CMAX) ? m_mc + 1 : CMAX;
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
